wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter N, default 32, data width of the register-file write port.
REQ-002 Parameter DEPTH, default 4, outstanding-load tag queue entries (power of 2, >=2).
REQ-003 Parameter STARVE_MAX, default 3, consecutive lost cycles before a held load response is forced through.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pipe_wr_en  in  1  write-back stage write request
- pipe_wr_reg  in  5  write-back destination register
- pipe_wr_data  in  N  write-back data
- pipe_stall  out  1  write-back stage write not accepted this cycle
- ld_issue  in  1  load issued to memory controller
- ld_issue_reg  in  5  load destination register
- ld_issue_ready  out  1  tag queue not full
- mem_rsp_valid  in  1  memory controller load data valid
- mem_rsp_data  in  N  load data
- mem_rsp_ready  out  1  response accepted when high with valid
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  N  register-file write data
- busy_vec  out  32  per-register pending-load scoreboard

Function
REQ-006 The tag queue SHALL hold load destination registers in issue order; push on ld_issue & ld_issue_ready; ld_issue while full SHALL be ignored.
REQ-007 ld_issue_ready SHALL equal (queue count < DEPTH), combinational from registered count.
REQ-008 Memory responses arrive in issue order; each accepted response SHALL pop the queue head as its destination.
REQ-009 mem_rsp_ready SHALL be 1 only when the hold register is empty and the queue is non-empty; responses with an empty queue are never accepted.
REQ-010 An accepted response SHALL load the hold register (data + popped register) on the same edge; a queue push and pop in the same cycle SHALL leave count unchanged.
REQ-011 The state machine SHALL have states IDLE (hold empty), HOLD (hold full, starve_cnt < STARVE_MAX), FORCE (hold full, starve_cnt == STARVE_MAX).
REQ-012 Transitions: IDLE->HOLD on response accept; HOLD->IDLE when load granted; HOLD->FORCE when starve_cnt reaches STARVE_MAX; FORCE->IDLE always on next edge (load granted).
REQ-013 Per-cycle grant: in HOLD, load SHALL be granted if pipe_wr_en=0 or pipe write is blocked by REQ-014; in FORCE, load SHALL be granted unconditionally; otherwise pipe write granted if pipe_wr_en=1 and not blocked.
REQ-014 A pipe write SHALL be blocked when busy_vec[pipe_wr_reg]=1 (WAW ordering).
REQ-015 pipe_stall SHALL be combinational: pipe_wr_en & (blocked or load granted).
REQ-016 starve_cnt SHALL increment each HOLD cycle the pipe wins, reset to 0 on load grant, saturating at STARVE_MAX.
REQ-017 Granted write SHALL appear on rf_we/rf_waddr/rf_wdata on the next cycle (latency 1); with no grant rf_we=0 and rf_waddr/rf_wdata hold last value.
REQ-018 busy_vec bit SHALL set on the edge after a load is pushed and clear on the edge its load is granted; simultaneous set and clear of the same bit SHALL leave it set.
REQ-019 Loads to the same register issued back-to-back SHALL keep busy set until the last one is granted (per-register pending counter, max DEPTH).
REQ-020 A response accepted in IDLE SHALL NOT be granted in the same cycle (earliest rf write is two cycles after acceptance).

Reset
REQ-021 On rst: queue empty, count 0, state IDLE, starve_cnt 0, busy_vec 0, rf_we 0, rf_waddr 0, rf_wdata 0, hold cleared; rst mid-operation SHALL discard all pending loads and held data.
REQ-022 During rst, mem_rsp_ready=0 and ld_issue_ready=0; pipe_stall follows REQ-015 from reset state values.

Verification
REQ-023 Pipe write r5=0x1234, no loads -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 next cycle, pipe_stall=0.
REQ-024 Issue load r7, response 0xBEEF, pipe idle -> busy_vec[7]=1 until rf write of r7=0xBEEF two cycles after accept, then busy_vec[7]=0.
REQ-025 Hold full, pipe writes every cycle to r1 (not busy) -> pipe wins 3 cycles, 4th cycle FORCE: pipe_stall=1, load written.
REQ-026 Issue 4 loads -> ld_issue_ready=0; 5th ld_issue ignored; responses write regs in issue order.
REQ-027 Load pending on r9, pipe write to r9 -> pipe_stall=1 until load r9 written, then pipe write lands next cycle.
REQ-028 Assert rst with 2 loads pending and hold full -> all outputs at reset values, busy_vec=0, later responses not accepted until new issue.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipe writes vs. in-order load responses via a one-entry hold, starvation forcing, WAW scoreboard.
// Latency 1 from grant to rf write (accepted load response is written 2 cycles after accept); pipe_stall / mem_rsp_ready / ld_issue_ready backpressure.
module wb_port_arbiter #(
  parameter int N          = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pipe_wr_en,
  input  logic [4:0]   pipe_wr_reg,
  input  logic [N-1:0] pipe_wr_data,
  output logic         pipe_stall,
  input  logic         ld_issue,
  input  logic [4:0]   ld_issue_reg,
  output logic         ld_issue_ready,
  input  logic         mem_rsp_valid,
  input  logic [N-1:0] mem_rsp_data,
  output logic         mem_rsp_ready,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [N-1:0] rf_wdata,
  output logic [31:0]  busy_vec
);

  localparam int QW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  // queue plus hold can carry DEPTH+1 loads to the same register
  localparam int PW = $clog2(DEPTH + 2);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;

  state_t        state, state_nxt;
  logic [4:0]    tag_q [DEPTH];
  logic [QW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [N-1:0]  hold_data;
  logic [4:0]    hold_reg;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [PW-1:0] pend_cnt [32];
  logic          push, pop, blocked, load_grant, pipe_grant;

  assign ld_issue_ready = !rst && (count < DEPTH_C);
  assign push           = ld_issue & ld_issue_ready;
  assign mem_rsp_ready  = !rst && (state == IDLE) && (count != '0);
  assign pop            = mem_rsp_valid & mem_rsp_ready;
  assign blocked        = busy_vec[pipe_wr_reg];
  assign pipe_stall     = pipe_wr_en & (blocked | load_grant);

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < 32; i++) busy_vec[i] = (pend_cnt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    load_grant = 1'b0;
    pipe_grant = 1'b0;
    case (state)
      IDLE: begin
        pipe_grant = pipe_wr_en & ~blocked;
        if (pop) state_nxt = HOLD;
      end
      HOLD: begin
        if (!pipe_wr_en || blocked) begin
          load_grant = 1'b1;
          starve_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          pipe_grant = 1'b1;
          if (starve_cnt < STARVE_C) starve_nxt = starve_cnt + SW'(1);
          if (starve_nxt == STARVE_C) state_nxt = FORCE;
        end
      end
      FORCE: begin
        load_grant = 1'b1;
        starve_nxt = '0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tag storage needs no reset: validity is tracked by count/pointers
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr] <= ld_issue_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_data  <= '0;
      hold_reg   <= '0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (push) wr_ptr <= wr_ptr + QW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + QW'(1);
        hold_data <= mem_rsp_data;
        hold_reg  <= tag_q[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (load_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= hold_reg;
      rf_wdata <= hold_data;
    end else if (pipe_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= pipe_wr_reg;
      rf_wdata <= pipe_wr_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // set and clear on the same register cancel, so the bit stays set
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst) begin
        pend_cnt[i] <= '0;
      end else begin
        case ({push && (ld_issue_reg == 5'(i)), load_grant && (hold_reg == 5'(i))})
          2'b10:   pend_cnt[i] <= pend_cnt[i] + PW'(1);
          2'b01:   pend_cnt[i] <= pend_cnt[i] - PW'(1);
          default: pend_cnt[i] <= pend_cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change 1ns after posedge, outputs checked before the next edge.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_reg;
  logic [31:0] pipe_wr_data;
  logic        pipe_stall;
  logic        ld_issue;
  logic [4:0]  ld_issue_reg;
  logic        ld_issue_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.N(32), .DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg), .pipe_wr_data(pipe_wr_data),
    .pipe_stall(pipe_stall),
    .ld_issue(ld_issue), .ld_issue_reg(ld_issue_reg), .ld_issue_ready(ld_issue_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pipe_wr_en = 1'b1; pipe_wr_reg = 5'd2; pipe_wr_data = 32'hDEAD;
    ld_issue = 1'b0; ld_issue_reg = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // reset state, with a pipe write held on the port
    tick(); tick();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("rst_ld_ready", 32'(ld_issue_ready), 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    rst = 1'b0; pipe_wr_en = 1'b0;

    // plain pipe write
    pipe_wr_en = 1'b1; pipe_wr_reg = 5'd5; pipe_wr_data = 32'h1234;
    #1;
    chk("pw_stall", 32'(pipe_stall), 32'd0);
    chk("pw_ld_ready", 32'(ld_issue_ready), 32'd1);
    chk("pw_rsp_ready_empty", 32'(mem_rsp_ready), 32'd0);
    tick(); pipe_wr_en = 1'b0;
    chk("pw_we", 32'(rf_we), 32'd1);
    chk("pw_waddr", 32'(rf_waddr), 32'd5);
    chk("pw_wdata", rf_wdata, 32'h1234);
    tick();
    chk("pw_we_off", 32'(rf_we), 32'd0);
    chk("pw_waddr_hold", 32'(rf_waddr), 32'd5);
    chk("pw_wdata_hold", rf_wdata, 32'h1234);

    // single load r7, pipe idle
    ld_issue = 1'b1; ld_issue_reg = 5'd7;
    tick(); ld_issue = 1'b0;
    chk("ld7_busy", busy_vec, 32'h0000_0080);
    chk("ld7_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF;
    tick(); mem_rsp_valid = 1'b0;
    chk("ld7_rsp_ready_held", 32'(mem_rsp_ready), 32'd0);
    chk("ld7_no_same_cycle", 32'(rf_we), 32'd0);
    chk("ld7_busy_held", busy_vec, 32'h0000_0080);
    tick();
    chk("ld7_we", 32'(rf_we), 32'd1);
    chk("ld7_waddr", 32'(rf_waddr), 32'd7);
    chk("ld7_wdata", rf_wdata, 32'hBEEF);
    chk("ld7_busy_clr", busy_vec, 32'd0);

    // starvation: pipe to r1 every cycle while load r3 is held
    ld_issue = 1'b1; ld_issue_reg = 5'd3;
    tick(); ld_issue = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE;
    tick(); mem_rsp_valid = 1'b0;
    pipe_wr_en = 1'b1; pipe_wr_reg = 5'd1;
    for (int k = 0; k < 3; k++) begin
      pipe_wr_data = 32'h11 + 32'(k);
      #1;
      chk("st_win_stall", 32'(pipe_stall), 32'd0);
      tick();
      chk("st_win_waddr", 32'(rf_waddr), 32'd1);
      chk("st_win_wdata", rf_wdata, 32'h11 + 32'(k));
    end
    pipe_wr_data = 32'h14;
    #1;
    chk("st_force_stall", 32'(pipe_stall), 32'd1);
    tick();
    chk("st_force_we", 32'(rf_we), 32'd1);
    chk("st_force_waddr", 32'(rf_waddr), 32'd3);
    chk("st_force_wdata", rf_wdata, 32'hCAFE);
    chk("st_force_busy", busy_vec, 32'd0);
    chk("st_after_stall", 32'(pipe_stall), 32'd0);
    tick(); pipe_wr_en = 1'b0;
    chk("st_after_waddr", 32'(rf_waddr), 32'd1);
    chk("st_after_wdata", rf_wdata, 32'h14);

    // fill the tag queue, 5th issue is dropped, responses drain in order
    for (int i = 0; i < 4; i++) begin
      ld_issue = 1'b1; ld_issue_reg = 5'(10 + i);
      tick();
    end
    ld_issue_reg = 5'd14;
    #1;
    chk("q_full_ready", 32'(ld_issue_ready), 32'd0);
    tick(); ld_issue = 1'b0;
    chk("q_busy", busy_vec, 32'h0000_3C00);
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA0 + 32'(i);
      #1;
      chk("q_rsp_ready", 32'(mem_rsp_ready), 32'd1);
      tick(); mem_rsp_valid = 1'b0;
      if (i == 0) chk("q_ld_ready_again", 32'(ld_issue_ready), 32'd1);
      tick();
      chk("q_waddr", 32'(rf_waddr), 32'(10 + i));
      chk("q_wdata", rf_wdata, 32'hA0 + 32'(i));
    end
    chk("q_busy_clr", busy_vec, 32'd0);
    chk("q_rsp_ready_empty", 32'(mem_rsp_ready), 32'd0);

    // WAW: pipe write to r9 waits for the pending load
    ld_issue = 1'b1; ld_issue_reg = 5'd9;
    tick(); ld_issue = 1'b0;
    pipe_wr_en = 1'b1; pipe_wr_reg = 5'd9; pipe_wr_data = 32'h55;
    #1;
    chk("waw_stall_idle", 32'(pipe_stall), 32'd1);
    tick();
    chk("waw_no_write", 32'(rf_we), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h99;
    tick(); mem_rsp_valid = 1'b0;
    chk("waw_stall_hold", 32'(pipe_stall), 32'd1);
    tick();
    chk("waw_ld_waddr", 32'(rf_waddr), 32'd9);
    chk("waw_ld_wdata", rf_wdata, 32'h99);
    chk("waw_stall_rel", 32'(pipe_stall), 32'd0);
    tick(); pipe_wr_en = 1'b0;
    chk("waw_pw_wdata", rf_wdata, 32'h55);

    // reset mid-operation: hold full, two loads queued
    for (int i = 0; i < 3; i++) begin
      ld_issue = 1'b1; ld_issue_reg = 5'(20 + i);
      tick();
    end
    ld_issue = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77;
    tick(); mem_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("mr_ld_ready", 32'(ld_issue_ready), 32'd0);
    chk("mr_stall", 32'(pipe_stall), 32'd0);
    tick(); rst = 1'b0;
    chk("mr_we", 32'(rf_we), 32'd0);
    chk("mr_waddr", 32'(rf_waddr), 32'd0);
    chk("mr_wdata", rf_wdata, 32'd0);
    chk("mr_busy", busy_vec, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h44;
    #1;
    chk("mr_rsp_ready_after", 32'(mem_rsp_ready), 32'd0);
    tick(); tick();
    chk("mr_no_stale_write", 32'(rf_we), 32'd0);
    ld_issue = 1'b1; ld_issue_reg = 5'd4;
    tick(); ld_issue = 1'b0;
    chk("mr_new_ready", 32'(mem_rsp_ready), 32'd1);
    tick(); mem_rsp_valid = 1'b0;
    tick();
    chk("mr_new_waddr", 32'(rf_waddr), 32'd4);
    chk("mr_new_wdata", rf_wdata, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
